// File: rtl/write_flash_control_pkg.sv
// Page geometry, block-table codes and controller state encoding.
// Shared by the page read and page program controllers.
// No logic: constants, types and one helper only.
package write_flash_control_pkg;

    localparam int PAGE_BYTES      = 8192;
    localparam int PAGES_PER_BLOCK = 128;

    localparam logic [1:0] ROW_PENDING = 2'd0;
    localparam logic [1:0] ROW_GOOD    = 2'd1;
    localparam logic [1:0] ROW_BAD     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_START,
        ST_WAIT_ADDR,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_RELOC
    } flash_state_e;

    // True when the block field of a row is all ones: relocation would wrap.
    function automatic logic is_last_block(input logic [23:0] row);
        return &(row | 24'(PAGES_PER_BLOCK - 1));
    endfunction

endpackage

// File: rtl/write_flash_control_wr_stream_buf.sv
// Streams page RAM bytes 0..N_BYTES-1 to the program datapath via a 2-entry buffer.
// Latency: first byte valid 2 cycles after active rises; 1 byte/cycle when ready is held.
// Backpressure: RAM reads stop when buffer plus in-flight read would overflow; no byte lost.
module write_flash_control_wr_stream_buf
    import write_flash_control_pkg::*;
#(
    parameter int N_BYTES = PAGE_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic [7:0]  wr_ram_dataout,
    input  logic        write_data_ready,
    output logic        wr_en_ram,
    output logic [14:0] wr_ram_addr,
    output logic [7:0]  write_data,
    output logic        write_data_valid,
    output logic        last_xfer
);

    localparam logic [14:0] LAST = 15'(N_BYTES - 1);

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [14:0]      rd_cnt_q, rd_cnt_d;
    logic [14:0]      tx_cnt_q, tx_cnt_d;
    logic [1:0][7:0]  buf_q, buf_d;
    logic             pop;
    logic [1:0]       occ_after_pop;

    always_comb begin
        pop           = (occ_q != 2'd0) & write_data_ready;
        occ_after_pop = occ_q - {1'b0, pop};
        // The read issued last cycle lands next edge, so it already owns a slot.
        wr_en_ram     = active & (rd_cnt_q <= LAST)
                        & ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
        wr_ram_addr   = wr_en_ram ? rd_cnt_q : 15'd0;

        write_data       = buf_q[0];
        write_data_valid = (occ_q != 2'd0);
        last_xfer        = pop & (tx_cnt_q == LAST);

        buf_d = buf_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (inflight_q) begin
            buf_d[occ_after_pop[0]] = wr_ram_dataout;
        end
        occ_d      = occ_after_pop + {1'b0, inflight_q};
        inflight_d = wr_en_ram;
        rd_cnt_d   = rd_cnt_q + {14'd0, wr_en_ram};
        tx_cnt_d   = tx_cnt_q + {14'd0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_cnt_q   <= 15'd0;
            tx_cnt_q   <= 15'd0;
            buf_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: rtl/write_flash_control.sv
// Page-program controller: block check, page stream, status wait, bad-block relocation.
// Latency: start edge to prog_start is CHK wait + 1 cycle; stream is PAGE_BYTES+2 cycles at full rate.
// Backpressure: write_data_ready stalls the stream; engine pulses are only honoured in their wait states.
module write_flash_control
    import write_flash_control_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_write,
    input  logic [23:0] write_addr_row_reg,
    output logic [23:0] write_addr_row,
    input  logic [1:0]  write_addr_row_error,
    output logic [14:0] wr_ram_addr,
    output logic        wr_en_ram,
    input  logic [7:0]  wr_ram_dataout,
    output logic        prog_start,
    input  logic        prog_addr_done,
    output logic [7:0]  write_data,
    output logic        write_data_valid,
    input  logic        write_data_ready,
    input  logic        prog_done,
    input  logic        prog_status_fail,
    output logic        bad_block_mark,
    output logic        write_busy,
    output logic        write_ok,
    output logic        write_fail
);

    localparam logic [23:0] BLOCK_STEP = 24'(PAGES_PER_BLOCK);
    localparam logic [7:0]  RETRY_LAST = 8'(MAX_RETRY - 1);

    flash_state_e state_q, state_d;
    logic [23:0]  row_q, row_d;
    logic [7:0]   retry_q, retry_d;
    logic         en_write_q, en_write_d;
    logic         busy_q, busy_d;
    logic         ok_q, ok_d;
    logic         fail_q, fail_d;
    logic         mark_q, mark_d;
    logic         stream_done;

    write_flash_control_wr_stream_buf #(
        .N_BYTES (PAGE_BYTES)
    ) u_stream (
        .clk              (clk),
        .rst              (rst),
        .active           (state_q == ST_STREAM),
        .wr_ram_dataout   (wr_ram_dataout),
        .write_data_ready (write_data_ready),
        .wr_en_ram        (wr_en_ram),
        .wr_ram_addr      (wr_ram_addr),
        .write_data       (write_data),
        .write_data_valid (write_data_valid),
        .last_xfer        (stream_done)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        retry_d    = retry_q;
        en_write_d = en_write;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
        mark_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // busy_q still covers the ok/fail pulse cycle, so edges there are dropped.
                if (en_write && !en_write_q && !busy_q) begin
                    row_d   = write_addr_row_reg;
                    retry_d = 8'd0;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                case (write_addr_row_error)
                    ROW_GOOD: state_d = ST_START;
                    ROW_BAD:  state_d = ST_RELOC;
                    default:  state_d = ST_CHK;
                endcase
            end
            ST_START:     state_d = ST_WAIT_ADDR;
            ST_WAIT_ADDR: if (prog_addr_done) state_d = ST_STREAM;
            ST_STREAM:    if (stream_done) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (prog_done) begin
                    if (prog_status_fail) begin
                        mark_d  = 1'b1;
                        state_d = ST_RELOC;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RELOC: begin
                if (retry_q == RETRY_LAST || is_last_block(row_q)) begin
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    row_d   = row_q + BLOCK_STEP;
                    retry_d = retry_q + 8'd1;
                    state_d = ST_CHK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) | ok_d | fail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= 24'd0;
            retry_q    <= 8'd0;
            en_write_q <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
            mark_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            retry_q    <= retry_d;
            en_write_q <= en_write_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
            mark_q     <= mark_d;
        end
    end

    assign write_addr_row = row_q;
    assign prog_start     = (state_q == ST_START);
    assign bad_block_mark = mark_q;
    assign write_busy     = busy_q;
    assign write_ok       = ok_q;
    assign write_fail     = fail_q;

endmodule

// File: tb/tb_write_flash_control.sv
// Directed bench for write_flash_control with a flash-engine/block-table driver,
// an outcome model (rows programmed/marked, ok/fail) and a per-cycle stream checker.
module tb_write_flash_control;

    localparam int PAGE = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_write = 1'b0;
    logic [23:0] write_addr_row_reg = 24'd0;
    logic [23:0] write_addr_row;
    logic [1:0]  write_addr_row_error = 2'd0;
    logic [14:0] wr_ram_addr;
    logic        wr_en_ram;
    logic [7:0]  wr_ram_dataout = 8'd0;
    logic        prog_start;
    logic        prog_addr_done = 1'b0;
    logic [7:0]  write_data;
    logic        write_data_valid;
    logic        write_data_ready = 1'b1;
    logic        prog_done = 1'b0;
    logic        prog_status_fail = 1'b0;
    logic        bad_block_mark;
    logic        write_busy;
    logic        write_ok;
    logic        write_fail;

    always #5 clk = ~clk;

    write_flash_control dut (
        .clk                  (clk),
        .rst                  (rst),
        .en_write             (en_write),
        .write_addr_row_reg   (write_addr_row_reg),
        .write_addr_row       (write_addr_row),
        .write_addr_row_error (write_addr_row_error),
        .wr_ram_addr          (wr_ram_addr),
        .wr_en_ram            (wr_en_ram),
        .wr_ram_dataout       (wr_ram_dataout),
        .prog_start           (prog_start),
        .prog_addr_done       (prog_addr_done),
        .write_data           (write_data),
        .write_data_valid     (write_data_valid),
        .write_data_ready     (write_data_ready),
        .prog_done            (prog_done),
        .prog_status_fail     (prog_status_fail),
        .bad_block_mark       (bad_block_mark),
        .write_busy           (write_busy),
        .write_ok             (write_ok),
        .write_fail           (write_fail)
    );

    // Synchronous page RAM holding byte i = i[7:0].
    always @(posedge clk) if (wr_en_ram) wr_ram_dataout <= wr_ram_addr[7:0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scenario knobs
    bit [7:0]    fail_pat = 8'h00;
    bit          rnd_ready = 1'b0;
    bit          bad_en = 1'b0;
    logic [16:0] bad_blk = 17'd0;
    int          rst_at = -1;
    bit          glitch = 1'b0;

    logic [23:0] starts[$], marks[$], exp_starts[$], exp_marks[$];
    int n_ok, n_fl, addr_done_cyc, first_valid_cyc, attempt_xfers;
    bit exp_ok;

    // Outcome model: walk blocks from row0, skipping table-bad blocks, consuming
    // one program result per attempt, giving up after 4 blocks or at the last block.
    task automatic build_model(input logic [23:0] row0);
        logic [23:0] row = row0;
        int retry = 0;
        int att = 0;
        bit fin = 0;
        exp_starts.delete();
        exp_marks.delete();
        exp_ok = 0;
        while (!fin) begin
            if (!(bad_en && row[23:7] == bad_blk)) begin
                exp_starts.push_back(row);
                if (!fail_pat[att]) begin
                    exp_ok = 1;
                    fin = 1;
                end else begin
                    exp_marks.push_back(row);
                    att++;
                end
            end
            if (!fin) begin
                if (retry == 3 || row[23:7] == 17'h1FFFF) fin = 1;
                else begin
                    row = row + 24'd128;
                    retry++;
                end
            end
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_row"}, {8'd0, write_addr_row}, 32'd0);
        check({tag, "_outs"}, {2'd0, wr_ram_addr, write_data, wr_en_ram, write_data_valid,
              prog_start, bad_block_mark, write_busy, write_ok, write_fail}, 32'd0);
    endtask

    task automatic compare_queues();
        check("n_prog_start", starts.size(), exp_starts.size());
        for (int i = 0; i < exp_starts.size() && i < starts.size(); i++)
            check("prog_start_row", starts[i], {8'd0, exp_starts[i]});
        check("n_bad_mark", marks.size(), exp_marks.size());
        for (int i = 0; i < exp_marks.size() && i < marks.size(); i++)
            check("bad_mark_row", marks[i], {8'd0, exp_marks[i]});
        check("n_write_ok", n_ok, {31'd0, exp_ok});
        check("n_write_fail", n_fl, {31'd0, !exp_ok});
    endtask

    // Drives en_write, block table and flash engine for one operation.
    task automatic run_op(input logic [23:0] row);
        int phase = 0, cnt = 0, cyc = 0, pend = 0, tot_xfer = 0, extra = 0;
        logic [1:0]  last_err = 2'd0;
        logic [23:0] last_row;
        logic        last_busy;
        bit          done = 0;
        starts.delete(); marks.delete();
        n_ok = 0; n_fl = 0; addr_done_cyc = -1; first_valid_cyc = -1; attempt_xfers = 0;
        write_addr_row_reg = row;
        en_write = 1'b1;
        last_row = write_addr_row;
        last_busy = write_busy;
        while (!done && cyc < 45000) begin
            @(posedge clk); #1; cyc++;
            if (rst) begin
                rst = 1'b0;
                check_quiet_outputs("after_mid_reset");
                done = 1;
            end else begin
                if (prog_start) begin
                    check("start_after_good", {30'd0, last_err}, 32'd1);
                    starts.push_back(write_addr_row);
                    phase = 1; cnt = 3; attempt_xfers = 0; first_valid_cyc = -1;
                end
                if (bad_block_mark) marks.push_back(write_addr_row);
                if (write_ok || write_fail) begin
                    check("busy_at_pulse", {31'd0, write_busy}, 32'd1);
                    n_ok += int'(write_ok); n_fl += int'(write_fail); done = 1;
                end
                if (write_data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (glitch && cyc == 10) en_write = 1'b0;
                if (glitch && cyc == 11) en_write = 1'b1;
                if (write_addr_row != last_row || (write_busy && !last_busy)) pend = 2;
                last_row = write_addr_row; last_busy = write_busy;
                if (pend > 0) begin
                    write_addr_row_error = 2'd0; pend--;
                end else begin
                    write_addr_row_error = (bad_en && write_addr_row[23:7] == bad_blk) ? 2'd2 : 2'd1;
                end
                last_err = write_addr_row_error;
                prog_addr_done = 1'b0; prog_done = 1'b0; prog_status_fail = 1'b0;
                write_data_ready = rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
                if (phase == 3) begin
                    if (cnt == 0) begin
                        prog_done = 1'b1;
                        prog_status_fail = fail_pat[starts.size() - 1];
                        phase = 0;
                    end else cnt--;
                end
                if (phase == 2) begin
                    if (attempt_xfers == 100) begin
                        prog_done = 1'b1; prog_addr_done = 1'b1; prog_status_fail = 1'b1;
                    end
                    if (write_data_valid && write_data_ready) begin
                        attempt_xfers++; tot_xfer++;
                        if (attempt_xfers == PAGE) begin phase = 3; cnt = 4; end
                    end
                    if (rst_at >= 0 && tot_xfer >= rst_at) begin
                        rst = 1'b1; en_write = 1'b0;
                    end
                end
                if (phase == 1) begin
                    if (cnt == 0) begin
                        prog_addr_done = 1'b1; addr_done_cyc = cyc; phase = 2;
                    end else cnt--;
                end
            end
        end
        check("op_completed", {31'd0, done}, 32'd1);
        en_write = 1'b0; prog_addr_done = 1'b0; prog_done = 1'b0;
        prog_status_fail = 1'b0; write_data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (prog_start || write_ok || write_fail || bad_block_mark || write_busy) extra++;
        end
        check("quiet_after_op", extra, 32'd0);
    endtask

    // Per-cycle stream checker: bytes in address order from 0 per attempt,
    // held stable under stall, never more than a page, RAM address idle at 0.
    int   exp_idx = 0;
    bit   prev_hold = 0;
    logic [7:0] prev_data = 8'd0;
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                exp_idx = 0; prev_hold = 0;
            end else begin
                if (prog_start) exp_idx = 0;
                if (!wr_en_ram) check("ram_addr_idle_zero", {17'd0, wr_ram_addr}, 32'd0);
                else check("ram_addr_in_page", {31'd0, (int'(wr_ram_addr) < PAGE)}, 32'd1);
                if (prev_hold) begin
                    check("stall_valid_held", {31'd0, write_data_valid}, 32'd1);
                    check("stall_data_held", {24'd0, write_data}, {24'd0, prev_data});
                end
                if (write_data_valid) check("no_byte_beyond_page", {31'd0, (exp_idx < PAGE)}, 32'd1);
                if (write_data_valid && write_data_ready) begin
                    check("byte_value", {24'd0, write_data}, exp_idx % 256);
                    exp_idx++;
                end
                check("ok_fail_exclusive", {31'd0, write_ok & write_fail}, 32'd0);
                prev_hold = write_data_valid & ~write_data_ready;
                prev_data = write_data;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_quiet_outputs("reset_state");

        // Good block, ready held high.
        build_model(24'h000105);
        run_op(24'h000105);
        compare_queues();
        check("t1_first_valid_delay", first_valid_cyc - addr_done_cyc, 32'd3);
        check("t1_transfers", attempt_xfers, PAGE);
        check("t1_row_held", {8'd0, write_addr_row}, 32'h000105);
        check("t1_ok_literal", n_ok, 32'd1);

        // Table-bad block relocates without a mark.
        bad_en = 1'b1; bad_blk = 17'h4;
        build_model(24'h000205);
        check("t3_model_row", {8'd0, exp_starts[0]}, 32'h000285);
        run_op(24'h000205);
        compare_queues();
        check("t3_no_mark_literal", marks.size(), 32'd0);
        bad_en = 1'b0;

        // Program fails once, then passes in the next block under random ready.
        fail_pat = 8'h01; rnd_ready = 1'b1;
        build_model(24'h000105);
        check("t4_model_mark", {8'd0, exp_marks[0]}, 32'h000105);
        run_op(24'h000105);
        compare_queues();
        check("t4_transfers", attempt_xfers, PAGE);
        rnd_ready = 1'b0;

        // Every attempt fails: four blocks tried, then give up.
        fail_pat = 8'hFF;
        build_model(24'h000105);
        run_op(24'h000105);
        compare_queues();
        check("t5_starts_literal", starts.size(), 32'd4);
        check("t5_fail_literal", n_fl, 32'd1);

        // Reset mid-stream, then a last-block failure with a spurious start edge.
        fail_pat = 8'h00; rst_at = 2000;
        run_op(24'h000105);
        check("t6_aborted_starts", starts.size(), 32'd1);
        check("t6_no_pulse", n_ok + n_fl, 32'd0);
        rst_at = -1; fail_pat = 8'h01; glitch = 1'b1;
        build_model(24'hFFFF85);
        check("t6_model_mark", {8'd0, exp_marks[0]}, 32'hFFFF85);
        run_op(24'hFFFF85);
        compare_queues();
        check("t6_transfers", attempt_xfers, PAGE);
        glitch = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
